pc_redirect_ctrl: RTL and testbench

//  Owns the architectural PC register and sequences next-PC for the single-cycle core.

---
 rtl/pc_redirect_ctrl_if.sv | 32 +++
 rtl/pc_redirect_ctrl.sv | 129 ++++++++++++
 tb/tb_pc_redirect_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/pc_redirect_ctrl_if.sv
// Redirect bus between the core's requesters/stall logic and the PC controller.
// The master drives stall and redirect requests; the slave (PC controller) returns the fetch PC.
interface pc_redirect_ctrl_if #(
    parameter int unsigned PC_WIDTH = 32
);
    logic                stall;
    logic                br_taken;
    logic [PC_WIDTH-1:0] br_target;
    logic                jal_valid;
    logic [PC_WIDTH-1:0] jal_target;
    logic                jalr_valid;
    logic [PC_WIDTH-1:0] jalr_target;
    logic                trap_valid;
    logic [PC_WIDTH-1:0] trap_vector;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] pc_plus4;
    logic                fetch_valid;
    logic                redirect;
    logic                misalign_exc;

    modport master (
        output stall, br_taken, br_target, jal_valid, jal_target,
               jalr_valid, jalr_target, trap_valid, trap_vector,
        input  pc, pc_plus4, fetch_valid, redirect, misalign_exc
    );

    modport slave (
        input  stall, br_taken, br_target, jal_valid, jal_target,
               jalr_valid, jalr_target, trap_valid, trap_vector,
        output pc, pc_plus4, fetch_valid, redirect, misalign_exc
    );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// Architectural PC register with prioritised redirect arbitration and stall buffering.
// Optional feature: define MISALIGN_TRAP_EN to trap on misaligned targets instead of truncating them.
module pc_redirect_ctrl #(
    parameter int unsigned         PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
    input logic               clk,
    input logic               rst,
    pc_redirect_ctrl_if.slave bus
);
    typedef enum logic [1:0] {BOOT, RUN, STALL} state_t;
    typedef enum logic [1:0] {PRIO_BR, PRIO_JAL, PRIO_JALR, PRIO_TRAP} prio_t;

    localparam logic [PC_WIDTH-1:0] JALR_MASK = {{(PC_WIDTH-1){1'b1}}, 1'b0};
`ifndef MISALIGN_TRAP_EN
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = {{(PC_WIDTH-2){1'b1}}, 2'b00};
`endif

    state_t              state;
    logic [PC_WIDTH-1:0] pc_q;
    logic                fetch_valid_q;
    logic                redirect_q;
    logic                misalign_exc_q;
    logic                pending_valid;
    logic [PC_WIDTH-1:0] pending_target;
    prio_t               pending_prio;
    logic                pending_misaligned;

    logic                any_req;
    logic [PC_WIDTH-1:0] sel_raw;
    logic [PC_WIDTH-1:0] sel_target;
    prio_t               sel_prio;
    logic                sel_misaligned;
    logic                live_wins;
    logic                apply_valid;
    logic [PC_WIDTH-1:0] apply_target;
    logic                apply_misaligned;

    // Fixed-priority select: trap, then JALR, then JAL, then branch.
    always_comb begin
        any_req  = bus.trap_valid | bus.jalr_valid | bus.jal_valid | bus.br_taken;
        sel_raw  = bus.br_target;
        sel_prio = PRIO_BR;
        if (bus.trap_valid) begin
            sel_raw  = bus.trap_vector;
            sel_prio = PRIO_TRAP;
        end else if (bus.jalr_valid) begin
            sel_raw  = bus.jalr_target & JALR_MASK;
            sel_prio = PRIO_JALR;
        end else if (bus.jal_valid) begin
            sel_raw  = bus.jal_target;
            sel_prio = PRIO_JAL;
        end
`ifdef MISALIGN_TRAP_EN
        sel_target     = sel_raw;
        sel_misaligned = (sel_prio != PRIO_TRAP) && (sel_raw[1:0] != 2'b00);
`else
        sel_target     = (sel_prio == PRIO_TRAP) ? sel_raw : (sel_raw & ALIGN_MASK);
        sel_misaligned = 1'b0;
`endif
    end

    // A live request beats the buffered one on equal priority; release after a stall only replays the buffer.
    always_comb begin
        live_wins        = any_req && (!pending_valid || (sel_prio >= pending_prio));
        apply_valid      = pending_valid || ((state == RUN) && any_req);
        apply_target     = pending_target;
        apply_misaligned = pending_misaligned;
        if ((state == RUN) && live_wins) begin
            apply_target     = sel_target;
            apply_misaligned = sel_misaligned;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= BOOT;
            pc_q               <= RESET_VECTOR;
            fetch_valid_q      <= 1'b0;
            redirect_q         <= 1'b0;
            misalign_exc_q     <= 1'b0;
            pending_valid      <= 1'b0;
            pending_target     <= '0;
            pending_prio       <= PRIO_BR;
            pending_misaligned <= 1'b0;
        end else begin
            redirect_q     <= 1'b0;
            misalign_exc_q <= 1'b0;
            case (state)
                BOOT: begin
                    state         <= RUN;
                    fetch_valid_q <= 1'b1;
                end
                RUN, STALL: begin
                    if (bus.stall) begin
                        state <= STALL;
                        if (live_wins) begin
                            pending_valid      <= 1'b1;
                            pending_target     <= sel_target;
                            pending_prio       <= sel_prio;
                            pending_misaligned <= sel_misaligned;
                        end
                    end else begin
                        state         <= RUN;
                        pending_valid <= 1'b0;
                        if (apply_valid) begin
                            redirect_q <= 1'b1;
                            if (apply_misaligned) begin
                                pc_q           <= bus.trap_vector;
                                misalign_exc_q <= 1'b1;
                            end else begin
                                pc_q <= apply_target;
                            end
                        end else begin
                            pc_q <= bus.pc_plus4;
                        end
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

    assign bus.pc           = pc_q;
    assign bus.pc_plus4     = pc_q + PC_WIDTH'(4);
    assign bus.fetch_valid  = fetch_valid_q;
    assign bus.redirect     = redirect_q;
    assign bus.misalign_exc = misalign_exc_q;
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed vector bench for pc_redirect_ctrl: table of per-cycle stimulus and expected PC,
// plus a hand-written reset-during-stall sequence. Honours MISALIGN_TRAP_EN.
module tb_pc_redirect_ctrl;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pc_redirect_ctrl_if #(.PC_WIDTH(32)) bus ();

    pc_redirect_ctrl #(
        .PC_WIDTH     (32),
        .RESET_VECTOR (32'h0000_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // req bits are {trap, jalr, jal, br}
    typedef struct {
        string       name;
        logic        stall;
        logic [3:0]  req;
        logic [31:0] br_t;
        logic [31:0] jal_t;
        logic [31:0] jalr_t;
        logic [31:0] trap_t;
        logic [31:0] exp_pc;
        logic        exp_red;
        logic        exp_exc;
    } vec_t;

    vec_t vecs[$];
    int   compared   = 0;
    int   mismatched = 0;

    function automatic vec_t mk(input string name, input logic st, input logic [3:0] req,
                                input logic [31:0] br_t, input logic [31:0] jal_t,
                                input logic [31:0] jalr_t, input logic [31:0] trap_t,
                                input logic [31:0] exp_pc, input logic exp_red,
                                input logic exp_exc);
        vec_t v;
        v.name = name; v.stall = st; v.req = req;
        v.br_t = br_t; v.jal_t = jal_t; v.jalr_t = jalr_t; v.trap_t = trap_t;
        v.exp_pc = exp_pc; v.exp_red = exp_red; v.exp_exc = exp_exc;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        bus.stall       = v.stall;
        bus.trap_valid  = v.req[3];
        bus.jalr_valid  = v.req[2];
        bus.jal_valid   = v.req[1];
        bus.br_taken    = v.req[0];
        bus.br_target   = v.br_t;
        bus.jal_target  = v.jal_t;
        bus.jalr_target = v.jalr_t;
        bus.trap_vector = v.trap_t;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] exp_pc,
                               input logic exp_red, input logic exp_exc, input logic exp_fv);
        compared++;
        if (bus.pc !== exp_pc) begin
            mismatched++;
            $display("[TB] FAIL %s pc: got %h expected %h", name, bus.pc, exp_pc);
        end
        compared++;
        if (bus.redirect !== exp_red) begin
            mismatched++;
            $display("[TB] FAIL %s redirect: got %b expected %b", name, bus.redirect, exp_red);
        end
        compared++;
        if (bus.misalign_exc !== exp_exc) begin
            mismatched++;
            $display("[TB] FAIL %s misalign_exc: got %b expected %b", name, bus.misalign_exc, exp_exc);
        end
        compared++;
        if (bus.fetch_valid !== exp_fv) begin
            mismatched++;
            $display("[TB] FAIL %s fetch_valid: got %b expected %b", name, bus.fetch_valid, exp_fv);
        end
        compared++;
        if (bus.pc_plus4 !== exp_pc + 32'd4) begin
            mismatched++;
            $display("[TB] FAIL %s pc_plus4: got %h expected %h", name, bus.pc_plus4, exp_pc + 32'd4);
        end
    endtask

    task automatic clearInputs();
        applyStimulus(mk("idle", 1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0));
    endtask

    initial begin
        logic [31:0] held_pc;

        vecs.push_back(mk("boot_exit",      0, 4'b0000, 32'h0,   32'h0,   32'h0,   32'h0,   32'h0000_0000, 0, 0));
        vecs.push_back(mk("seq_4",          0, 4'b0000, 32'h0,   32'h0,   32'h0,   32'h0,   32'h0000_0004, 0, 0));
        vecs.push_back(mk("seq_8",          0, 4'b0000, 32'h0,   32'h0,   32'h0,   32'h0,   32'h0000_0008, 0, 0));
        vecs.push_back(mk("br_taken",       0, 4'b0001, 32'h100, 32'h0,   32'h0,   32'h0,   32'h0000_0100, 1, 0));
        vecs.push_back(mk("jal_over_br",    0, 4'b0011, 32'h80,  32'h200, 32'h0,   32'h0,   32'h0000_0200, 1, 0));
        vecs.push_back(mk("seq_after_jal",  0, 4'b0000, 32'h0,   32'h0,   32'h0,   32'h0,   32'h0000_0204, 0, 0));
        vecs.push_back(mk("jalr_bit0",      0, 4'b0100, 32'h0,   32'h0,   32'h301, 32'h0,   32'h0000_0300, 1, 0));
        vecs.push_back(mk("jal_0x40",       0, 4'b0010, 32'h0,   32'h40,  32'h0,   32'h0,   32'h0000_0040, 1, 0));
        vecs.push_back(mk("stall_br",       1, 4'b0001, 32'h90,  32'h0,   32'h0,   32'h0,   32'h0000_0040, 0, 0));
        vecs.push_back(mk("stall_trap",     1, 4'b1000, 32'h0,   32'h0,   32'h0,   32'h800, 32'h0000_0040, 0, 0));
        vecs.push_back(mk("stall_jal_drop", 1, 4'b0010, 32'h0,   32'h500, 32'h0,   32'h0,   32'h0000_0040, 0, 0));
        vecs.push_back(mk("release_trap",   0, 4'b0000, 32'h0,   32'h0,   32'h0,   32'h0,   32'h0000_0800, 1, 0));
        vecs.push_back(mk("seq_after_trap", 0, 4'b0000, 32'h0,   32'h0,   32'h0,   32'h0,   32'h0000_0804, 0, 0));
        vecs.push_back(mk("stall_idle",     1, 4'b0000, 32'h0,   32'h0,   32'h0,   32'h0,   32'h0000_0804, 0, 0));
        vecs.push_back(mk("release_idle",   0, 4'b0000, 32'h0,   32'h0,   32'h0,   32'h0,   32'h0000_0808, 0, 0));
        vecs.push_back(mk("stall_br_a",     1, 4'b0001, 32'h60,  32'h0,   32'h0,   32'h0,   32'h0000_0808, 0, 0));
        vecs.push_back(mk("stall_br_b",     1, 4'b0001, 32'h70,  32'h0,   32'h0,   32'h0,   32'h0000_0808, 0, 0));
        vecs.push_back(mk("release_br_b",   0, 4'b0000, 32'h0,   32'h0,   32'h0,   32'h0,   32'h0000_0070, 1, 0));
        vecs.push_back(mk("trap_over_all",  0, 4'b1111, 32'h10,  32'h20,  32'h30,  32'h900, 32'h0000_0900, 1, 0));
`ifdef MISALIGN_TRAP_EN
        vecs.push_back(mk("br_misalign",    0, 4'b0001, 32'h102, 32'h0,   32'h0,   32'hA00, 32'h0000_0A00, 1, 1));
`else
        vecs.push_back(mk("br_misalign",    0, 4'b0001, 32'h102, 32'h0,   32'h0,   32'hA00, 32'h0000_0100, 1, 0));
`endif
        vecs.push_back(mk("jal_top",        0, 4'b0010, 32'h0,   32'hFFFF_FFFC, 32'h0, 32'h0, 32'hFFFF_FFFC, 1, 0));
        vecs.push_back(mk("wrap",           0, 4'b0000, 32'h0,   32'h0,   32'h0,   32'h0,   32'h0000_0000, 0, 0));
        vecs.push_back(mk("stall_jal_mis",  1, 4'b0010, 32'h0,   32'h206, 32'h0,   32'h0,   32'h0000_0000, 0, 0));
`ifdef MISALIGN_TRAP_EN
        vecs.push_back(mk("release_mis",    0, 4'b0000, 32'h0,   32'h0,   32'h0,   32'hB00, 32'h0000_0B00, 1, 1));
        vecs.push_back(mk("seq_after_mis",  0, 4'b0000, 32'h0,   32'h0,   32'h0,   32'h0,   32'h0000_0B04, 0, 0));
`else
        vecs.push_back(mk("release_mis",    0, 4'b0000, 32'h0,   32'h0,   32'h0,   32'hB00, 32'h0000_0204, 1, 0));
        vecs.push_back(mk("seq_after_mis",  0, 4'b0000, 32'h0,   32'h0,   32'h0,   32'h0,   32'h0000_0208, 0, 0));
`endif

        rst = 1'b1;
        clearInputs();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", 32'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        checkOutput("boot", 32'h0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            @(posedge clk);
            #1;
            checkOutput(vecs[i].name, vecs[i].exp_pc, vecs[i].exp_red, vecs[i].exp_exc, 1'b1);
        end

        // Reset while a branch is buffered under stall: pending must not survive into RUN.
        held_pc = vecs[vecs.size()-1].exp_pc;
        applyStimulus(mk("rst_stall_br", 1, 4'b0001, 32'h300, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0));
        @(posedge clk);
        #1;
        checkOutput("rst_stall_hold", held_pc, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        applyStimulus(mk("rst_with_trap", 1, 4'b1000, 32'h0, 32'h0, 32'h0, 32'h700, 32'h0, 0, 0));
        @(posedge clk);
        #1;
        checkOutput("rst_mid_stall", 32'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        clearInputs();
        @(posedge clk);
        #1;
        checkOutput("rst_boot_exit", 32'h0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("rst_no_replay", 32'h4, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("rst_seq_8", 32'h8, 1'b0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
